// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction-fetch slice: instruction width,
// fetch FSM state encoding and default reset/halt constants.
package cpu_pkg;

    localparam int INSTR_W = 16;

    localparam logic [15:0] DEFAULT_RESET_PC  = 16'h0000;
    localparam logic [15:0] DEFAULT_HALT_WORD = 16'h0000;

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_CAPTURE = 2'd1,
        S_ISSUE   = 2'd2,
        S_HALT    = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the
// controller/execute stage. "master" is the fetch-unit side.
interface fetch_unit_if
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
);

    // instruction memory
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd;
    logic [INSTR_W-1:0] mem_rdata;

    // issue handshake towards decoder/controller
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic               instr_ready;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  link_pc;

    // redirect from execute/controller
    logic               redir_valid;
    logic               redir_abs;
    logic [ADDR_W-1:0]  redir_target;
    logic [INSTR_W-1:0] redir_offset;

    logic               halted;

    modport master (
        output mem_addr, mem_rd, instr_out, instr_valid, pc, link_pc, halted,
        input  mem_rdata, instr_ready, redir_valid, redir_abs, redir_target, redir_offset
    );

    modport slave (
        input  mem_addr, mem_rd, instr_out, instr_valid, pc, link_pc, halted,
        output mem_rdata, instr_ready, redir_valid, redir_abs, redir_target, redir_offset
    );

endinterface

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: sequential increment, PC-relative branch
// or absolute jump. All arithmetic wraps modulo 2^ADDR_W.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0]  pc,
    input  logic               redir_valid,
    input  logic               redir_abs,
    input  logic [ADDR_W-1:0]  redir_target,
    input  logic [INSTR_W-1:0] redir_offset,
    output logic [ADDR_W-1:0]  pc_next
);

    // Select the successor address; the displacement is already sign-extended
    // by the decoder, so truncation to ADDR_W gives correct two's-complement wrap.
    always_comb begin
        pc_next = pc + ADDR_W'(1);
        if (redir_valid) begin
            if (redir_abs) begin
                pc_next = redir_target;
            end else begin
                pc_next = pc + redir_offset[ADDR_W-1:0];
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, reads the synchronous instruction
// memory, latches the word into the instruction register and issues it with
// a valid/ready handshake. Redirects are applied when an instruction is
// accepted.
// Optional: define FETCH_HALT_EN to stop fetching on HALT_WORD (S_HALT,
// exit only by reset). Without it HALT_WORD is an ordinary instruction.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
`ifdef FETCH_HALT_EN
    ,
    parameter logic [INSTR_W-1:0] HALT_WORD = DEFAULT_HALT_WORD
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_unit_if.master bus
);

    fetch_state_t       state_reg, state_next;
    logic [ADDR_W-1:0]  pc_reg, pc_next;
    logic [ADDR_W-1:0]  pc_target;
    logic [INSTR_W-1:0] instr_reg, instr_next;
    logic               valid_reg, valid_next;

    pc_next_calc #(
        .ADDR_W(ADDR_W)
    ) u_pc_next_calc (
        .pc          (pc_reg),
        .redir_valid (bus.redir_valid),
        .redir_abs   (bus.redir_abs),
        .redir_target(bus.redir_target),
        .redir_offset(bus.redir_offset),
        .pc_next     (pc_target)
    );

`ifdef FETCH_HALT_EN
    logic halted_reg, halted_next;
`endif

    // State, PC and instruction register update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            pc_reg    <= RESET_PC;
            instr_reg <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
            valid_reg <= valid_next;
        end
    end

`ifdef FETCH_HALT_EN
    // Sticky halt flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_reg <= 1'b0;
        end else begin
            halted_reg <= halted_next;
        end
    end
`endif

    // Next-state and register-load decisions; redirects are consumed only
    // on an accepted issue, so they are ignored in every other cycle.
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;
        valid_next = valid_reg;
`ifdef FETCH_HALT_EN
        halted_next = halted_reg;
`endif
        case (state_reg)
            S_FETCH: begin
                state_next = S_CAPTURE;
            end
            S_CAPTURE: begin
`ifdef FETCH_HALT_EN
                if (bus.mem_rdata == HALT_WORD) begin
                    halted_next = 1'b1;
                    state_next  = S_HALT;
                end else begin
                    instr_next = bus.mem_rdata;
                    valid_next = 1'b1;
                    state_next = S_ISSUE;
                end
`else
                instr_next = bus.mem_rdata;
                valid_next = 1'b1;
                state_next = S_ISSUE;
`endif
            end
            S_ISSUE: begin
                if (bus.instr_ready) begin
                    valid_next = 1'b0;
                    pc_next    = pc_target;
                    state_next = S_FETCH;
                end
            end
            S_HALT: begin
                state_next = S_HALT;
            end
        endcase
    end

    // The read strobe is suppressed while reset is held so the bus is idle
    // even though the FSM already sits in S_FETCH.
    assign bus.mem_rd      = rst_n && (state_reg == S_FETCH);
    assign bus.mem_addr    = pc_reg;
    assign bus.pc          = pc_reg;
    assign bus.link_pc     = pc_reg + ADDR_W'(1);
    assign bus.instr_out   = instr_reg;
    assign bus.instr_valid = valid_reg;
`ifdef FETCH_HALT_EN
    assign bus.halted      = halted_reg;
`else
    assign bus.halted      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver pushes expected issues and
// fetch addresses into queues; a negedge monitor pops and compares.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_W(ADDR_W)) bus();

    fetch_unit #(
        .ADDR_W  (ADDR_W),
        .RESET_PC(16'h0000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // synchronous-read instruction memory model
    logic [15:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
    } iss_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] instr;
        logic [7:0]  stall;
        logic        rv;
        logic        rabs;
        logic [15:0] target;
        logic [15:0] off;
        logic [15:0] nfetch;
    } stim_t;

    iss_t        iss_q[$];
    logic [15:0] fetch_q[$];
    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor: compares fetch addresses and accepted issues against the queues
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.mem_rd) begin
                if (fetch_q.size() == 0) begin
                    check("fetch_unexpected", bus.mem_addr, 16'hxxxx);
                end else begin
                    check("fetch_addr", bus.mem_addr, fetch_q.pop_front());
                end
            end
            if (bus.instr_valid && bus.instr_ready) begin
                if (iss_q.size() == 0) begin
                    check("issue_unexpected", bus.instr_out, 16'hxxxx);
                end else begin
                    iss_t e;
                    e = iss_q.pop_front();
                    check("issue_instr", bus.instr_out, e.instr);
                    check("issue_pc", bus.pc, e.pc);
                    check("issue_link", bus.link_pc, e.pc + 16'd1);
                    check("issue_halted", {15'b0, bus.halted}, 16'h0000);
                    $display("[TB] issue pc=%h instr=%h link=%h", bus.pc, bus.instr_out, bus.link_pc);
                end
            end
        end
    end

    task automatic issue_one(input stim_t s);
        int n;
        iss_q.push_back('{pc: s.pc, instr: s.instr});
        fetch_q.push_back(s.nfetch);
        n = 0;
        while (!bus.instr_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.instr_valid) check("issue_timeout", 16'h0000, 16'h0001);
        // back-pressure; junk redirect must be ignored while not ready
        for (int i = 0; i < int'(s.stall); i++) begin
            bus.redir_valid  = 1'b1;
            bus.redir_abs    = 1'b1;
            bus.redir_target = 16'h7777;
            check("stall_valid", {15'b0, bus.instr_valid}, 16'h0001);
            check("stall_instr", bus.instr_out, s.instr);
            check("stall_mem_rd", {15'b0, bus.mem_rd}, 16'h0000);
            check("stall_pc", bus.pc, s.pc);
            @(posedge clk); #1;
        end
        bus.instr_ready  = 1'b1;
        bus.redir_valid  = s.rv;
        bus.redir_abs    = s.rabs;
        bus.redir_target = s.target;
        bus.redir_offset = s.off;
        @(posedge clk); #1;
        bus.instr_ready  = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_abs    = 1'b0;
        bus.redir_target = 16'h0000;
        bus.redir_offset = 16'h0000;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    stim_t stims[$];

    initial begin
        int cnt;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[0]      = 16'h5301;
`ifdef FETCH_HALT_EN
        mem[1]      = 16'h0000;
`else
        mem[1]      = 16'h0352;
`endif
        mem[2]      = 16'hD10A;
        mem[3]      = 16'h0000;
        mem[4]      = 16'h4444;
        mem[8]      = 16'hA5A5;
        mem[13]     = 16'h1313;
        mem[16'h10] = 16'h7010;
        mem[16'h200]= 16'h2BAD;
        mem[16'hFFFF] = 16'hFFEE;

        rst_n            = 1'b0;
        bus.instr_ready  = 1'b0;
        bus.redir_valid  = 1'b0;
        bus.redir_abs    = 1'b0;
        bus.redir_target = 16'h0000;
        bus.redir_offset = 16'h0000;
        @(posedge clk); #2;
        check("rst_mem_rd", {15'b0, bus.mem_rd}, 16'h0000);
        check("rst_valid", {15'b0, bus.instr_valid}, 16'h0000);
        check("rst_instr", bus.instr_out, 16'h0000);
        check("rst_pc", bus.pc, 16'h0000);
        check("rst_mem_addr", bus.mem_addr, 16'h0000);
        check("rst_halted", {15'b0, bus.halted}, 16'h0000);

        fetch_q.push_back(16'h0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        cnt = 0;
        while (!bus.instr_valid && cnt < 10) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("first_valid_latency", 16'(cnt), 16'd2);

`ifdef FETCH_HALT_EN
        issue_one('{16'h0000, 16'h5301, 8'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0001});
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            check("halt_halted", {15'b0, bus.halted}, 16'h0001);
            check("halt_valid", {15'b0, bus.instr_valid}, 16'h0000);
            check("halt_mem_rd", {15'b0, bus.mem_rd}, 16'h0000);
            check("halt_pc", bus.pc, 16'h0001);
            @(posedge clk); #1;
        end
`else
        //              pc        instr     stall rv    abs   target    offset    next fetch
        stims.push_back('{16'h0000, 16'h5301, 8'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001});
        stims.push_back('{16'h0001, 16'h0352, 8'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0002});
        stims.push_back('{16'h0002, 16'hD10A, 8'd5, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0003});
        stims.push_back('{16'h0003, 16'h0000, 8'd0, 1'b1, 1'b1, 16'h0008, 16'h0000, 16'h0008});
        stims.push_back('{16'h0008, 16'hA5A5, 8'd0, 1'b1, 1'b0, 16'h0000, 16'hFFFC, 16'h0004});
        stims.push_back('{16'h0004, 16'h4444, 8'd0, 1'b1, 1'b1, 16'h0008, 16'h0000, 16'h0008});
        stims.push_back('{16'h0008, 16'hA5A5, 8'd0, 1'b1, 1'b0, 16'h0000, 16'h0005, 16'h000D});
        stims.push_back('{16'h000D, 16'h1313, 8'd0, 1'b1, 1'b1, 16'h0010, 16'h0000, 16'h0010});
        stims.push_back('{16'h0010, 16'h7010, 8'd0, 1'b1, 1'b1, 16'h0200, 16'h0000, 16'h0200});
        stims.push_back('{16'h0200, 16'h2BAD, 8'd0, 1'b1, 1'b1, 16'hFFFF, 16'h0000, 16'hFFFF});
        stims.push_back('{16'hFFFF, 16'hFFEE, 8'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000});
        stims.push_back('{16'h0000, 16'h5301, 8'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001});
        foreach (stims[k]) issue_one(stims[k]);

        // reset asserted while the word at pc=1 is being captured
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {15'b0, bus.instr_valid}, 16'h0000);
        check("midrst_mem_rd", {15'b0, bus.mem_rd}, 16'h0000);
        check("midrst_pc", bus.pc, 16'h0000);
        check("midrst_instr", bus.instr_out, 16'h0000);
        @(posedge clk); #1;
        check("midrst_hold_valid", {15'b0, bus.instr_valid}, 16'h0000);
        fetch_q.push_back(16'h0000);
        rst_n = 1'b1;
        issue_one('{16'h0000, 16'h5301, 8'd0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0001});
`endif

        repeat (6) @(posedge clk);
        #1;
        check("fetch_q_drained", 16'(fetch_q.size()), 16'd0);
        check("iss_q_drained", 16'(iss_q.size()), 16'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
